multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Multicycle control unit for the ARM-like CPU. Replaces single-cycle decode by sequencing one shared ALU, one unified instruction/data memory port and the register file across 3–5 cycles per instruction. Also owns the NZCV flag register and condition-code evaluation. Sits between the instruction register (Op/Funct/Rd/Cond fields) and the datapath mux selects and write enables.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- Cond  in  4  instruction [31:28]
- Op  in  2  instruction [27:26]
- Funct  in  6  instruction [25:20] (I=Funct[5], cmd=Funct[4:1], S/L=Funct[0])
- Rd  in  4  instruction [15:12]
- ALUFlags  in  4  ALU {N,Z,C,V} for the current cycle
- PCWrite, RegWrite, MemWrite, IRWrite  out  1 each  gated write enables
- AdrSrc  out  1  memory address: 0=PC, 1=Result
- ALUSrcA  out  1  0=register A, 1=PC
- ALUSrcB  out  2  00=register B, 01=ExtImm, 10=constant 4
- ResultSrc  out  2  00=ALUOut reg, 01=Data reg, 10=ALU result
- ImmSrc  out  2  equals Op
- RegSrc  out  2  [0]=(Op==10), [1]=(Op==01)
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- illegal  out  1  high in DECODE when Op==11 or unsupported cmd

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10, PCWrite=1 unconditionally. -> DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10; latch condex_q = CondCheck(Cond, flags_q). Next: Op=01->MEMADR; Op=00 & Funct[5]=0->EXECR; Op=00 & Funct[5]=1->EXECI; Op=10->BRANCH; Op=11 or unsupported cmd->FETCH (NOP, illegal=1).
- MEMADR: ALUSrcA=0, ALUSrcB=01, ADD. Funct[0]=1->MEMREAD else MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00 -> MEMWB. MEMWB: ResultSrc=01, RegW -> FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemW -> FETCH.
- EXECR/EXECI: ALUSrcA=0, ALUSrcB=00/01, ALUControl from cmd -> ALUWB. ALUWB: ResultSrc=00, RegW unless CMP -> FETCH.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ADD, ResultSrc=10, Branch -> FETCH.
- cmd decode: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP (SUB, no write). Non-EXEC states force ADD.
- Gating: RegWrite=RegW&condex_q; MemWrite=MemW&condex_q; PCWrite=FETCH | (PCS&condex_q), PCS=Branch | (RegW & Rd==15).
- Flags: in EXECR/EXECI with S=1 and condex_q, NZ<=ALUFlags[3:2]; CV<=ALUFlags[1:0] only for ADD/SUB/CMP.
- CondCheck: EQ,NE,CS,CC,MI,PL,VS,VC,HI,LS,GE,LT,GT,LE per ARM; 1110 AL=1; 1111=0.

## Timing
- Reset: state=FETCH, flags_q=0000, condex_q=0; while reset=1 PCWrite, RegWrite, MemWrite, IRWrite are forced 0.
- First cycle after reset deasserts: FETCH outputs.
- Cycles per instruction: B 3, STR 4, DP/CMP 4, LDR 5, illegal 2.
- Mid-instruction reset: next state FETCH, no pending write completes.
- All control outputs combinational from state, Op/Funct/Rd and condex_q; no registered outputs.
- Flags written by an instruction affect the condition check of the next instruction only.

## Structure
- Package cpu_ctrl_pkg: state enum, ALUControl codes, ALUSrcB/ResultSrc encodings, condition-code constants.
- Sub-module cond_logic: flags_q register, CondCheck, condex_q latch, write-enable gating.

## Test plan
- Reset held 3 cycles, then released -> all write enables 0 during reset; FETCH on first free cycle with IRWrite=1, PCWrite=1.
- ADDS R1,R2,R3 (Cond=1110, Op=00, Funct=001001) with ALUFlags=0100 -> FETCH,DECODE,EXECR,ALUWB; RegWrite=1 in ALUWB; flags_q=0100.
- LDR (Op=01, Funct=011001) -> 5-state path, AdrSrc=1 in MEMREAD, ResultSrc=01 and RegWrite=1 in MEMWB.
- BEQ with flags_q Z=0 -> BRANCH reached, PCWrite=0 there; with Z=1 -> PCWrite=1.
- CMP setting Z=1 then ADDNE R0 -> CMP gives RegWrite=0 in ALUWB; ADDNE gives RegWrite=0, flags unchanged.
- Reset asserted in MEMWRITE -> MemWrite=0 that cycle, FETCH next.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// cpu_ctrl_pkg : state, mux-select, ALU and condition encodings for the
//                multicycle ARM-like controller.            Rev 1.0
// ============================================================================
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_e;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  // flags are packed {N,Z,C,V}
  function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v, ok;
    {n, z, c, v} = flags;
    case (cond)
      COND_EQ: ok = z;
      COND_NE: ok = ~z;
      COND_CS: ok = c;
      COND_CC: ok = ~c;
      COND_MI: ok = n;
      COND_PL: ok = ~n;
      COND_VS: ok = v;
      COND_VC: ok = ~v;
      COND_HI: ok = c & ~z;
      COND_LS: ok = ~c | z;
      COND_GE: ok = (n == v);
      COND_LT: ok = (n != v);
      COND_GT: ok = ~z & (n == v);
      COND_LE: ok = z | (n != v);
      COND_AL: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic cmd_supported(input logic [3:0] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_AND) ||
           (cmd == CMD_ORR) || (cmd == CMD_CMP);
  endfunction

  function automatic logic [1:0] alu_ctrl(input logic [3:0] cmd);
    logic [1:0] sel;
    case (cmd)
      CMD_SUB, CMD_CMP: sel = ALU_SUB;
      CMD_AND:          sel = ALU_AND;
      CMD_ORR:          sel = ALU_ORR;
      default:          sel = ALU_ADD;
    endcase
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cond_logic.sv
`default_nettype none
// ============================================================================
// cond_logic : NZCV flag register, condition latch and write-enable gating.
//                                                            Rev 1.0
// ============================================================================
module cond_logic
  import cpu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond_i,
  input  logic [3:0] alu_flags_i,
  input  logic       cond_latch_i,
  input  logic       flags_we_nz_i,
  input  logic       flags_we_cv_i,
  input  logic       reg_w_i,
  input  logic       mem_w_i,
  input  logic       pcs_i,
  input  logic       fetch_i,
  output logic       reg_write_o,
  output logic       mem_write_o,
  output logic       pc_write_o
);

  logic [3:0] flags_q, flags_d;
  logic       condex_q, condex_d;

  // Flag writes are qualified by the condition of the instruction being executed.
  always_comb begin
    flags_d  = flags_q;
    condex_d = condex_q;
    if (cond_latch_i)
      condex_d = cond_check(cond_i, flags_q);
    if (flags_we_nz_i && condex_q)
      flags_d[3:2] = alu_flags_i[3:2];
    if (flags_we_cv_i && condex_q)
      flags_d[1:0] = alu_flags_i[1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q  <= 4'b0000;
      condex_q <= 1'b0;
    end else begin
      flags_q  <= flags_d;
      condex_q <= condex_d;
    end
  end

  assign reg_write_o = ~reset & reg_w_i & condex_q;
  assign mem_write_o = ~reset & mem_w_i & condex_q;
  assign pc_write_o  = ~reset & (fetch_i | (pcs_i & condex_q));

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// multicycle_controller : instruction sequencer driving the shared ALU,
//                         memory port and register file.      Rev 1.0
// ============================================================================
module multicycle_controller
  import cpu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUControl,
  output logic       illegal
);

  state_e     state_q, state_d;
  logic [3:0] cmd;
  logic       ir_w, reg_w, mem_w, branch, pcs, fetch;
  logic       cond_latch, flags_we_nz, flags_we_cv;

  assign cmd = Funct[4:1];

  always_comb begin
    state_d     = state_q;
    AdrSrc      = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_REG;
    ResultSrc   = RES_ALUOUT;
    ALUControl  = ALU_ADD;
    illegal     = 1'b0;
    ir_w        = 1'b0;
    reg_w       = 1'b0;
    mem_w       = 1'b0;
    branch      = 1'b0;
    fetch       = 1'b0;
    cond_latch  = 1'b0;
    flags_we_nz = 1'b0;
    flags_we_cv = 1'b0;
    case (state_q)
      S_FETCH: begin
        fetch     = 1'b1;
        ir_w      = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_FOUR;
        ResultSrc  = RES_ALU;
        cond_latch = 1'b1;
        case (Op)
          2'b01: state_d = S_MEMADR;
          2'b10: state_d = S_BRANCH;
          2'b00: begin
            if (!cmd_supported(cmd)) begin
              illegal = 1'b1;
              state_d = S_FETCH;
            end else begin
              state_d = Funct[5] ? S_EXECI : S_EXECR;
            end
          end
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcB = SRCB_IMM;
        state_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        reg_w     = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc  = 1'b1;
        mem_w   = 1'b1;
        state_d = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        ALUSrcB     = (state_q == S_EXECI) ? SRCB_IMM : SRCB_REG;
        ALUControl  = alu_ctrl(cmd);
        flags_we_nz = Funct[0];
        // Logical ops leave C and V untouched.
        flags_we_cv = Funct[0] &&
                      ((cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_CMP));
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_w   = (cmd != CMD_CMP);
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALU;
        branch    = 1'b1;
        state_d   = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  assign pcs     = branch | (reg_w & (Rd == 4'd15));
  assign IRWrite = ir_w & ~reset;
  assign ImmSrc  = Op;
  assign RegSrc  = {(Op == 2'b01), (Op == 2'b10)};

  cond_logic u_cond (
    .clk          (clk),
    .reset        (reset),
    .cond_i       (Cond),
    .alu_flags_i  (ALUFlags),
    .cond_latch_i (cond_latch),
    .flags_we_nz_i(flags_we_nz),
    .flags_we_cv_i(flags_we_cv),
    .reg_w_i      (reg_w),
    .mem_w_i      (mem_w),
    .pcs_i        (pcs),
    .fetch_i      (fetch),
    .reg_write_o  (RegWrite),
    .mem_write_o  (MemWrite),
    .pc_write_o   (PCWrite)
  );

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// tb_multicycle_controller : directed scenarios plus randomized instruction
//                            streams against an instruction-level model.
// ============================================================================
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] Cond = 4'hE;
  logic [1:0] Op = 2'b00;
  logic [5:0] Funct = 6'd0;
  logic [3:0] Rd = 4'd0;
  logic [3:0] ALUFlags = 4'd0;
  logic       PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc, ALUSrcA, illegal;
  logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;

  logic [16:0] obs;
  int          n_pass = 0;
  int          n_total = 0;
  logic [3:0]  m_flags = 4'h0;
  logic [3:0]  CMDS [0:4] = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010};

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl),
    .illegal(illegal)
  );

  assign obs = {PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc, ALUSrcA, ALUSrcB,
                ResultSrc, ImmSrc, RegSrc, ALUControl, illegal};

  // ---------------- instruction-level reference model ----------------
  function automatic bit m_cond(input logic [3:0] c, input logic [3:0] f);
    bit base;
    case (c[3:1])
      3'd0: base = f[2];
      3'd1: base = f[1];
      3'd2: base = f[3];
      3'd3: base = f[0];
      3'd4: base = f[1] && !f[2];
      3'd5: base = (f[3] == f[0]);
      3'd6: base = !f[2] && (f[3] == f[0]);
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  function automatic bit m_legal(input logic [1:0] op, input logic [5:0] f);
    int cmd;
    cmd = int'(f[4:1]);
    if (op == 2'b01 || op == 2'b10) return 1'b1;
    if (op == 2'b00) return (cmd == 4 || cmd == 2 || cmd == 0 || cmd == 12 || cmd == 10);
    return 1'b0;
  endfunction

  function automatic int m_len(input logic [1:0] op, input logic [5:0] f);
    if (!m_legal(op, f)) return 2;
    if (op == 2'b10) return 3;
    if (op == 2'b01) return f[0] ? 5 : 4;
    return 4;
  endfunction

  function automatic logic [1:0] m_alu(input logic [3:0] cmd);
    case (cmd)
      4'b0010, 4'b1010: return 2'd1;
      4'b0000:          return 2'd2;
      4'b1100:          return 2'd3;
      default:          return 2'd0;
    endcase
  endfunction

  // Expected outputs for cycle k of an instruction, with a care mask for the
  // selects that are only defined in some cycles.
  function automatic void m_cycle(input int k, input logic [1:0] op, input logic [5:0] f,
                                  input logic [3:0] rd, input bit cex,
                                  output logic [16:0] exp, output logic [16:0] mask);
    bit pcw, rw, mw, irw, adr, sa, ill;
    logic [1:0] sb, rs, alu;
    logic [16:0] care;
    bit is_cmp;
    pcw = 0; rw = 0; mw = 0; irw = 0; adr = 0; sa = 0; ill = 0;
    sb = 0; rs = 0; alu = 0;
    care = 17'h1E07F;
    is_cmp = (f[4:1] == 4'b1010);
    if (k == 0) begin
      irw = 1; pcw = 1; sa = 1; sb = 2; rs = 2; care |= 17'h01F80;
    end else if (k == 1) begin
      sa = 1; sb = 2; rs = 2; ill = !m_legal(op, f); care |= 17'h00F80;
    end else if (op == 2'b10) begin
      sb = 1; rs = 2; pcw = cex; care |= 17'h00F80;
    end else if (op == 2'b01) begin
      if (k == 2) begin sb = 1; care |= 17'h00E00; end
      else if (k == 3) begin adr = 1; mw = !f[0] && cex; care |= 17'h01180; end
      else begin rs = 1; rw = cex; pcw = cex && (rd == 4'hF); care |= 17'h00180; end
    end else begin
      if (k == 2) begin sb = f[5] ? 2'd1 : 2'd0; alu = m_alu(f[4:1]); care |= 17'h00E00; end
      else begin rw = cex && !is_cmp; pcw = rw && (rd == 4'hF); care |= 17'h00180; end
    end
    exp  = {pcw, rw, mw, irw, adr, sa, sb, rs, op, {(op == 2'b01), (op == 2'b10)}, alu, ill};
    mask = care;
  endfunction

  // ---------------- stimulus helpers (drive only) ----------------
  task automatic step(input logic rst, input logic [3:0] c, input logic [1:0] op,
                      input logic [5:0] f, input logic [3:0] rd, input logic [3:0] af);
    @(negedge clk);
    reset = rst; Cond = c; Op = op; Funct = f; Rd = rd; ALUFlags = af;
    #1;
  endtask

  task automatic exec_adds(input logic [3:0] af);
    step(0, 4'hE, 2'b00, 6'b001001, 4'd3, 4'h0);
    step(0, 4'hE, 2'b00, 6'b001001, 4'd3, 4'h0);
    step(0, 4'hE, 2'b00, 6'b001001, 4'd3, af);
    step(0, 4'hE, 2'b00, 6'b001001, 4'd3, 4'h0);
    m_flags = af;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      step(1, 4'hE, 2'b01, 6'b011000, 4'hF, 4'h0);
      n_total++;
      if ({PCWrite, RegWrite, MemWrite, IRWrite} !== 4'b0000)
        $display("FAIL reset_we cycle %0d: got %b, want 0000", i, {PCWrite, RegWrite, MemWrite, IRWrite});
      else n_pass++;
    end
    n_total++;
    if (dut.u_cond.flags_q !== 4'h0) $display("FAIL reset_flags: got %b, want 0000", dut.u_cond.flags_q);
    else n_pass++;
    step(0, 4'hE, 2'b11, 6'd0, 4'd0, 4'h0);
    n_total++;
    if ({IRWrite, PCWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc} !== 8'b11011010)
      $display("FAIL reset_first_fetch: got %b, want 11011010", {IRWrite, PCWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc});
    else n_pass++;
    step(0, 4'hE, 2'b11, 6'd0, 4'd0, 4'h0);
    n_total++;
    if ({illegal, PCWrite, IRWrite} !== 3'b100)
      $display("FAIL illegal_decode: got %b, want 100", {illegal, PCWrite, IRWrite});
    else n_pass++;
    m_flags = 4'h0;
  endtask

  task automatic test_adds;
    step(0, 4'hE, 2'b00, 6'b001001, 4'd1, 4'h0);
    n_total++;
    if ({IRWrite, PCWrite} !== 2'b11) $display("FAIL adds_fetch: got %b, want 11", {IRWrite, PCWrite});
    else n_pass++;
    step(0, 4'hE, 2'b00, 6'b001001, 4'd1, 4'h0);
    n_total++;
    if ({illegal, ALUSrcA, ALUSrcB, IRWrite} !== 5'b01100)
      $display("FAIL adds_decode: got %b, want 01100", {illegal, ALUSrcA, ALUSrcB, IRWrite});
    else n_pass++;
    step(0, 4'hE, 2'b00, 6'b001001, 4'd1, 4'b0100);
    n_total++;
    if ({ALUSrcA, ALUSrcB, ALUControl, RegWrite} !== 6'b000000)
      $display("FAIL adds_execr: got %b, want 000000", {ALUSrcA, ALUSrcB, ALUControl, RegWrite});
    else n_pass++;
    step(0, 4'hE, 2'b00, 6'b001001, 4'd1, 4'h0);
    n_total++;
    if ({RegWrite, ResultSrc, PCWrite} !== 4'b1000)
      $display("FAIL adds_aluwb: got %b, want 1000", {RegWrite, ResultSrc, PCWrite});
    else n_pass++;
    n_total++;
    if (dut.u_cond.flags_q !== 4'b0100) $display("FAIL adds_flags: got %b, want 0100", dut.u_cond.flags_q);
    else n_pass++;
    m_flags = 4'b0100;
  endtask

  task automatic test_ldr;
    step(0, 4'hE, 2'b01, 6'b011001, 4'd2, 4'h0);
    n_total++;
    if (IRWrite !== 1'b1) $display("FAIL ldr_fetch: got %b, want 1", IRWrite);
    else n_pass++;
    step(0, 4'hE, 2'b01, 6'b011001, 4'd2, 4'h0);
    step(0, 4'hE, 2'b01, 6'b011001, 4'd2, 4'h0);
    n_total++;
    if ({ALUSrcA, ALUSrcB, ALUControl} !== 5'b00100)
      $display("FAIL ldr_memadr: got %b, want 00100", {ALUSrcA, ALUSrcB, ALUControl});
    else n_pass++;
    step(0, 4'hE, 2'b01, 6'b011001, 4'd2, 4'h0);
    n_total++;
    if ({AdrSrc, ResultSrc, RegWrite, MemWrite} !== 5'b10000)
      $display("FAIL ldr_memread: got %b, want 10000", {AdrSrc, ResultSrc, RegWrite, MemWrite});
    else n_pass++;
    step(0, 4'hE, 2'b01, 6'b011001, 4'd2, 4'h0);
    n_total++;
    if ({ResultSrc, RegWrite, PCWrite} !== 4'b0110)
      $display("FAIL ldr_memwb: got %b, want 0110", {ResultSrc, RegWrite, PCWrite});
    else n_pass++;
  endtask

  task automatic test_branch;
    exec_adds(4'b0000);
    step(0, 4'b0000, 2'b10, 6'h2A, 4'd0, 4'h0);
    step(0, 4'b0000, 2'b10, 6'h2A, 4'd0, 4'h0);
    step(0, 4'b0000, 2'b10, 6'h2A, 4'd0, 4'h0);
    n_total++;
    if ({ALUSrcA, ALUSrcB, PCWrite} !== 4'b0010)
      $display("FAIL beq_not_taken: got %b, want 0010", {ALUSrcA, ALUSrcB, PCWrite});
    else n_pass++;
    exec_adds(4'b0100);
    step(0, 4'b0000, 2'b10, 6'h15, 4'd0, 4'h0);
    step(0, 4'b0000, 2'b10, 6'h15, 4'd0, 4'h0);
    step(0, 4'b0000, 2'b10, 6'h15, 4'd0, 4'h0);
    n_total++;
    if ({ALUSrcB, ResultSrc, PCWrite} !== 5'b01101)
      $display("FAIL beq_taken: got %b, want 01101", {ALUSrcB, ResultSrc, PCWrite});
    else n_pass++;
  endtask

  task automatic test_cmp_addne;
    exec_adds(4'b0000);
    step(0, 4'hE, 2'b00, 6'b010101, 4'hF, 4'h0);
    step(0, 4'hE, 2'b00, 6'b010101, 4'hF, 4'h0);
    step(0, 4'hE, 2'b00, 6'b010101, 4'hF, 4'b0100);
    n_total++;
    if (ALUControl !== 2'b01) $display("FAIL cmp_aluctl: got %b, want 01", ALUControl);
    else n_pass++;
    step(0, 4'hE, 2'b00, 6'b010101, 4'hF, 4'h0);
    n_total++;
    if ({RegWrite, PCWrite} !== 2'b00) $display("FAIL cmp_nowrite: got %b, want 00", {RegWrite, PCWrite});
    else n_pass++;
    n_total++;
    if (dut.u_cond.flags_q !== 4'b0100) $display("FAIL cmp_flags: got %b, want 0100", dut.u_cond.flags_q);
    else n_pass++;
    m_flags = 4'b0100;
    step(0, 4'b0001, 2'b00, 6'b001001, 4'd0, 4'h0);
    step(0, 4'b0001, 2'b00, 6'b001001, 4'd0, 4'h0);
    step(0, 4'b0001, 2'b00, 6'b001001, 4'd0, 4'b1011);
    step(0, 4'b0001, 2'b00, 6'b001001, 4'd0, 4'h0);
    n_total++;
    if (RegWrite !== 1'b0) $display("FAIL addne_regwrite: got %b, want 0", RegWrite);
    else n_pass++;
    n_total++;
    if (dut.u_cond.flags_q !== 4'b0100) $display("FAIL addne_flags: got %b, want 0100", dut.u_cond.flags_q);
    else n_pass++;
  endtask

  task automatic test_reset_midinstr;
    step(0, 4'hE, 2'b01, 6'b011000, 4'd4, 4'h0);
    step(0, 4'hE, 2'b01, 6'b011000, 4'd4, 4'h0);
    step(0, 4'hE, 2'b01, 6'b011000, 4'd4, 4'h0);
    step(1, 4'hE, 2'b01, 6'b011000, 4'd4, 4'h0);
    n_total++;
    if ({MemWrite, RegWrite, PCWrite, IRWrite} !== 4'b0000)
      $display("FAIL midreset_memwrite: got %b, want 0000", {MemWrite, RegWrite, PCWrite, IRWrite});
    else n_pass++;
    step(0, 4'hE, 2'b11, 6'd0, 4'd0, 4'h0);
    n_total++;
    if ({IRWrite, PCWrite, AdrSrc, MemWrite} !== 4'b1100)
      $display("FAIL midreset_fetch: got %b, want 1100", {IRWrite, PCWrite, AdrSrc, MemWrite});
    else n_pass++;
    n_total++;
    if (dut.u_cond.flags_q !== 4'h0) $display("FAIL midreset_flags: got %b, want 0000", dut.u_cond.flags_q);
    else n_pass++;
    m_flags = 4'h0;
    step(0, 4'hE, 2'b11, 6'd0, 4'd0, 4'h0);
    n_total++;
    if ({illegal, PCWrite} !== 2'b10) $display("FAIL midreset_illegal: got %b, want 10", {illegal, PCWrite});
    else n_pass++;
  endtask

  task automatic test_random(input int n_instr);
    logic [3:0]  c, rd, af;
    logic [1:0]  op;
    logic [5:0]  f;
    logic [16:0] exp, mask;
    bit          cex;
    int          len;
    for (int i = 0; i < n_instr; i++) begin
      op = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      f  = 6'($urandom);
      if (op == 2'b00 && $urandom_range(0, 7) != 0) f[4:1] = CMDS[$urandom_range(0, 4)];
      c   = ($urandom_range(0, 2) == 0) ? 4'hE : 4'($urandom);
      rd  = ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom);
      cex = m_cond(c, m_flags);
      len = m_len(op, f);
      for (int k = 0; k < len; k++) begin
        af = 4'($urandom);
        step(0, c, op, f, rd, af);
        m_cycle(k, op, f, rd, cex, exp, mask);
        n_total++;
        if ((obs & mask) !== (exp & mask))
          $display("FAIL random i=%0d k=%0d cond=%b op=%b funct=%b rd=%0d: got %h, want %h (mask %h)",
                   i, k, c, op, f, rd, obs & mask, exp & mask, mask);
        else n_pass++;
        if (k == 2 && op == 2'b00 && f[0] && cex) begin
          m_flags[3:2] = af[3:2];
          if (f[4:1] == 4'b0100 || f[4:1] == 4'b0010 || f[4:1] == 4'b1010) m_flags[1:0] = af[1:0];
        end
      end
      n_total++;
      if (dut.u_cond.flags_q !== m_flags)
        $display("FAIL random_flags i=%0d: got %b, want %b", i, dut.u_cond.flags_q, m_flags);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_adds();
    test_ldr();
    test_branch();
    test_cmp_addne();
    test_reset_midinstr();
    test_random(400);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
